ibex_offload_wb_arbiter: RTL and testbench

// Shares the register-file write port between the core writeback path and

---
 rtl/ibex_offload_wb_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ibex_offload_wb_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_offload_wb_arbiter.sv
// ibex_offload_wb_arbiter
//
// Shares the register-file write port between the core writeback stage and
// results coming back from an offload coprocessor. The core always wins the
// port. Coprocessor results wait in a small FIFO and drain whenever the core
// is not writing. A per-register busy scoreboard tracks destinations of
// offload instructions that have issued but not yet retired, so ID/EX can
// stall on RAW/WAW hazards against them.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   core_we_i/waddr/wdata writeback-stage RF write request (highest priority)
//   off_issue_i/rd_i     offload instruction with writeback wants to issue
//   off_issue_ready_o    issue may proceed (outstanding room, no WAW)
//   off_result_*         coprocessor result stream, ready = FIFO not full
//   rf_we_o/waddr/wdata  register-file write port
//   rd_busy_o            bit i set: an offload write to x<i> is pending
//   outstanding_o        issued-but-not-retired offload count
//   off_done_o           single-cycle pulse when an offload result retires

module ibex_offload_wb_arbiter #(
    parameter int unsigned FifoDepth      = 2,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned OutW          = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            core_we_i,
    input  logic [4:0]      core_waddr_i,
    input  logic [31:0]     core_wdata_i,

    input  logic            off_issue_i,
    input  logic [4:0]      off_issue_rd_i,
    output logic            off_issue_ready_o,

    input  logic            off_result_valid_i,
    output logic            off_result_ready_o,
    input  logic            off_result_we_i,
    input  logic [4:0]      off_result_rd_i,
    input  logic [31:0]     off_result_data_i,

    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [31:0]     rf_wdata_o,

    output logic [31:0]     rd_busy_o,
    output logic [OutW-1:0] outstanding_o,
    output logic            off_done_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);
    localparam logic [OutW-1:0] MaxOut  = OutW'(MaxOutstanding);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [OutW-1:0] out_q, out_d;
    logic [31:0]     busy_q, busy_d;

    // Result storage is not reset; only the pointers/count define validity.
    logic            fifo_we_q   [FifoDepth];
    logic [4:0]      fifo_rd_q   [FifoDepth];
    logic [31:0]     fifo_data_q [FifoDepth];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        issue_ready;
    logic        issue_fire;
    logic        head_we;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        // Explicit wrap so non-power-of-two depths stay in range.
        if (ptr == LastPtr) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    always_comb begin
        full        = (count_q == FullCnt);
        empty       = (count_q == '0);
        head_we     = fifo_we_q[rptr_q];
        head_rd     = fifo_rd_q[rptr_q];
        head_data   = fifo_data_q[rptr_q];
        // Ready depends on current occupancy only: a full FIFO refuses a
        // result even when it is popping this cycle.
        push        = off_result_valid_i & ~full;
        // The core owns the write port whenever it writes.
        pop         = ~empty & ~core_we_i;
        issue_ready = (out_q < MaxOut) & ~busy_q[off_issue_rd_i];
        issue_fire  = off_issue_i & issue_ready;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        out_d   = out_q;
        busy_d  = busy_q;

        if (push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        case ({issue_fire, pop})
            2'b10:   out_d = out_q + OutW'(1);
            2'b01:   out_d = out_q - OutW'(1);
            default: out_d = out_q;
        endcase

        // Set and clear never hit the same register: an issue to a busy rd
        // is stalled, so a retiring rd cannot be re-issued in that cycle.
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (issue_fire && (off_issue_rd_i != 5'd0)) begin
            busy_d[off_issue_rd_i] = 1'b1;
        end
        // x0 is hardwired, never tracked.
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
            busy_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_we_q[wptr_q]   <= off_result_we_i;
            fifo_rd_q[wptr_q]   <= off_result_rd_i;
            fifo_data_q[wptr_q] <= off_result_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        off_issue_ready_o  = issue_ready;
        off_result_ready_o = ~full;
        rd_busy_o          = busy_q;
        outstanding_o      = out_q;
        off_done_o         = pop;

        if (pop) begin
            // A result with we=0 still retires, it just does not write.
            rf_we_o    = head_we & (head_rd != 5'd0);
            rf_waddr_o = head_rd;
            rf_wdata_o = head_data;
        end else begin
            rf_we_o    = core_we_i;
            rf_waddr_o = core_waddr_i;
            rf_wdata_o = core_wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_retire_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pop && (head_rd != 5'd0)) |-> busy_q[head_rd]);

    a_core_not_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (core_we_i && (core_waddr_i != 5'd0)) |-> !busy_q[core_waddr_i]);

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (out_q != '0));

    a_fifo_le_out: assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(count_q) <= 32'(out_q));

endmodule

// File: tb/tb_ibex_offload_wb_arbiter.sv
// Bench for ibex_offload_wb_arbiter: directed scenarios plus a random phase.
// The stimulus process pushes every accepted result into a queue of expected
// retirements; a separate monitor compares the DUT's write port against that
// queue and against a simple model of pending destinations.

module tb_ibex_offload_wb_arbiter;

    localparam int unsigned FifoDepth = 2;
    localparam int unsigned MaxOut    = 4;
    localparam int unsigned OutW      = $clog2(MaxOut + 1);

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b1;
    logic            core_we_i = 1'b0;
    logic [4:0]      core_waddr_i = '0;
    logic [31:0]     core_wdata_i = '0;
    logic            off_issue_i = 1'b0;
    logic [4:0]      off_issue_rd_i = '0;
    logic            off_issue_ready_o;
    logic            off_result_valid_i = 1'b0;
    logic            off_result_ready_o;
    logic            off_result_we_i = 1'b0;
    logic [4:0]      off_result_rd_i = '0;
    logic [31:0]     off_result_data_i = '0;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [31:0]     rf_wdata_o;
    logic [31:0]     rd_busy_o;
    logic [OutW-1:0] outstanding_o;
    logic            off_done_o;

    ibex_offload_wb_arbiter #(
        .FifoDepth      (FifoDepth),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .core_we_i          (core_we_i),
        .core_waddr_i       (core_waddr_i),
        .core_wdata_i       (core_wdata_i),
        .off_issue_i        (off_issue_i),
        .off_issue_rd_i     (off_issue_rd_i),
        .off_issue_ready_o  (off_issue_ready_o),
        .off_result_valid_i (off_result_valid_i),
        .off_result_ready_o (off_result_ready_o),
        .off_result_we_i    (off_result_we_i),
        .off_result_rd_i    (off_result_rd_i),
        .off_result_data_i  (off_result_data_i),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_wdata_o         (rf_wdata_o),
        .rd_busy_o          (rd_busy_o),
        .outstanding_o      (outstanding_o),
        .off_done_o         (off_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    // Reference model: accepted-but-unretired results, issued-but-unanswered
    // destinations, pending destination set, pending instruction count.
    res_t       exp_q[$];
    logic [4:0] issued_q[$];
    logic [31:0] busy_m = '0;
    int         out_m = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: handshakes are judged from the model at the falling edge and
    // the model is updated just after the rising edge.
    task automatic tick();
        logic       iss;
        logic       res;
        logic [4:0] ird;
        res_t       r;
        @(negedge clk_i);
        ird = off_issue_rd_i;
        iss = off_issue_i && (out_m < MaxOut) && !busy_m[ird];
        res = off_result_valid_i && (exp_q.size() < FifoDepth);
        r.we   = off_result_we_i;
        r.rd   = off_result_rd_i;
        r.data = off_result_data_i;
        @(posedge clk_i);
        if (rst_ni) begin
            if (iss) begin
                out_m++;
                if (ird != 5'd0) busy_m[ird] = 1'b1;
                issued_q.push_back(ird);
            end
            if (res) begin
                exp_q.push_back(r);
                void'(issued_q.pop_front());
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        core_we_i          = 1'b0;
        core_waddr_i       = '0;
        core_wdata_i       = '0;
        off_issue_i        = 1'b0;
        off_issue_rd_i     = '0;
        off_result_valid_i = 1'b0;
        off_result_we_i    = 1'b0;
        off_result_rd_i    = '0;
        off_result_data_i  = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        exp_q.delete();
        issued_q.delete();
        busy_m = '0;
        out_m  = 0;
        #1;
        chk("rst_now_outstanding", 32'(outstanding_o), 0);
        chk("rst_now_busy", rd_busy_o, 0);
        @(posedge clk_i);
        #1;
        chk("rst_outstanding", 32'(outstanding_o), 0);
        chk("rst_busy", rd_busy_o, 0);
        chk("rst_done", 32'(off_done_o), 0);
        chk("rst_result_ready", 32'(off_result_ready_o), 1);
        chk("rst_rf_we", 32'(rf_we_o), 0);
        rst_ni = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd);
        off_issue_i    = 1'b1;
        off_issue_rd_i = rd;
        tick();
        off_issue_i    = 1'b0;
    endtask

    task automatic set_result(input logic we, input logic [4:0] rd, input logic [31:0] data);
        off_result_valid_i = 1'b1;
        off_result_we_i    = we;
        off_result_rd_i    = rd;
        off_result_data_i  = data;
    endtask

    // Answer every issued instruction and let everything retire.
    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 100 && (issued_q.size() > 0 || exp_q.size() > 0); i++) begin
            if (issued_q.size() > 0) set_result(1'b1, issued_q[0], $urandom());
            else off_result_valid_i = 1'b0;
            tick();
        end
        off_result_valid_i = 1'b0;
        #1;
        chk("drain_outstanding", 32'(outstanding_o), 0);
        chk("drain_busy", rd_busy_o, 0);
    endtask

    task automatic rand_cycle();
        logic [4:0] a;
        core_we_i = ($urandom_range(0, 99) < 30);
        a = 5'($urandom_range(0, 31));
        if (busy_m[a]) a = 5'd0;
        core_waddr_i   = a;
        core_wdata_i   = $urandom();
        off_issue_i    = ($urandom_range(0, 99) < 40);
        off_issue_rd_i = 5'($urandom_range(0, 7));
        if (issued_q.size() > 0 && $urandom_range(0, 99) < 50) begin
            set_result(1'($urandom_range(0, 1)), issued_q[0], $urandom());
        end else begin
            off_result_valid_i = 1'b0;
            off_result_rd_i    = 5'($urandom_range(0, 31));
        end
        tick();
    endtask

    // Monitor: checks every cycle out of reset, retires the queue head when
    // the DUT is expected to pop.
    initial begin
        res_t head;
        logic retire;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                retire = (exp_q.size() != 0) && !core_we_i;
                chk("off_done", 32'(off_done_o), 32'(retire));
                if (core_we_i) begin
                    chk("core_rf_we", 32'(rf_we_o), 1);
                    chk("core_rf_waddr", 32'(rf_waddr_o), 32'(core_waddr_i));
                    chk("core_rf_wdata", rf_wdata_o, core_wdata_i);
                end else if (retire) begin
                    head = exp_q[0];
                    chk("ret_rf_we", 32'(rf_we_o), 32'(head.we && (head.rd != 5'd0)));
                    chk("ret_rf_waddr", 32'(rf_waddr_o), 32'(head.rd));
                    chk("ret_rf_wdata", rf_wdata_o, head.data);
                end else begin
                    chk("idle_rf_we", 32'(rf_we_o), 0);
                    chk("idle_rf_waddr", 32'(rf_waddr_o), 32'(core_waddr_i));
                    chk("idle_rf_wdata", rf_wdata_o, core_wdata_i);
                end
                chk("result_ready", 32'(off_result_ready_o), 32'(exp_q.size() < FifoDepth));
                chk("issue_ready", 32'(off_issue_ready_o),
                    32'((out_m < MaxOut) && !busy_m[off_issue_rd_i]));
                chk("rd_busy", rd_busy_o, busy_m);
                chk("outstanding", 32'(outstanding_o), 32'(out_m));
                @(posedge clk_i);
                if (retire && rst_ni) begin
                    head = exp_q.pop_front();
                    if (head.rd != 5'd0) busy_m[head.rd] = 1'b0;
                    out_m--;
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2;
        do_reset();

        // Single result retires one cycle after acceptance.
        issue(5'd5);
        set_result(1'b1, 5'd5, 32'hCAFEF00D);
        tick();
        off_result_valid_i = 1'b0;
        #1;
        chk("t1_rf_we", 32'(rf_we_o), 1);
        chk("t1_rf_waddr", 32'(rf_waddr_o), 5);
        chk("t1_rf_wdata", rf_wdata_o, 32'hCAFEF00D);
        chk("t1_done", 32'(off_done_o), 1);
        chk("t1_busy_held", 32'(rd_busy_o[5]), 1);
        tick();
        #1;
        chk("t1_busy_clear", 32'(rd_busy_o[5]), 0);

        // Core holds the port for three cycles, FIFO drains on the fourth.
        issue(5'd6);
        set_result(1'b1, 5'd6, 32'h1234);
        core_we_i    = 1'b1;
        core_waddr_i = 5'd7;
        core_wdata_i = 32'h11;
        tick();
        off_result_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_core_waddr", 32'(rf_waddr_o), 7);
            chk("t2_hold", 32'(off_done_o), 0);
            tick();
        end
        core_we_i = 1'b0;
        #1;
        chk("t2_drain_done", 32'(off_done_o), 1);
        chk("t2_drain_waddr", 32'(rf_waddr_o), 6);
        tick();

        // Outstanding limit.
        for (int r = 1; r <= 4; r++) issue(5'(r));
        off_issue_i    = 1'b1;
        off_issue_rd_i = 5'd5;
        #1;
        chk("t3_full_stall", 32'(off_issue_ready_o), 0);
        set_result(1'b1, 5'd1, 32'hA1);
        tick();
        off_result_valid_i = 1'b0;
        #1;
        chk("t3_retire_cycle", 32'(off_issue_ready_o), 0);
        tick();
        #1;
        chk("t3_ready_after", 32'(off_issue_ready_o), 1);
        tick();
        off_issue_i = 1'b0;
        drain();

        // WAW stall, and rd=0 issue.
        issue(5'd9);
        off_issue_i    = 1'b1;
        off_issue_rd_i = 5'd9;
        repeat (2) begin
            #1;
            chk("t4_waw_stall", 32'(off_issue_ready_o), 0);
            tick();
        end
        set_result(1'b1, 5'd9, 32'h99);
        tick();
        off_result_valid_i = 1'b0;
        tick();
        #1;
        chk("t4_waw_release", 32'(off_issue_ready_o), 1);
        tick();
        off_issue_i = 1'b0;
        issue(5'd0);
        #1;
        chk("t4_rd0_outstanding", 32'(outstanding_o), 2);
        chk("t4_rd0_busy", rd_busy_o, 32'h0000_0200);
        drain();

        // FIFO full with core busy, then in-order drain.
        issue(5'd10);
        issue(5'd11);
        issue(5'd12);
        core_we_i    = 1'b1;
        core_waddr_i = 5'd1;
        core_wdata_i = 32'h55;
        set_result(1'b1, 5'd10, 32'h100);
        tick();
        set_result(1'b1, 5'd11, 32'h110);
        tick();
        set_result(1'b1, 5'd12, 32'h120);
        #1;
        chk("t5_full", 32'(off_result_ready_o), 0);
        tick();
        core_we_i = 1'b0;
        #1;
        chk("t5_no_passthru", 32'(off_result_ready_o), 0);
        chk("t5_pop1_addr", 32'(rf_waddr_o), 10);
        tick();
        #1;
        chk("t5_ready_again", 32'(off_result_ready_o), 1);
        chk("t5_pop2_addr", 32'(rf_waddr_o), 11);
        tick();
        off_result_valid_i = 1'b0;
        drain();

        // we=0 result, then reset mid-stream.
        issue(5'd3);
        set_result(1'b0, 5'd3, 32'hDEAD);
        tick();
        off_result_valid_i = 1'b0;
        #1;
        chk("t6_no_write", 32'(rf_we_o), 0);
        chk("t6_done", 32'(off_done_o), 1);
        tick();
        #1;
        chk("t6_busy3_clear", 32'(rd_busy_o[3]), 0);
        issue(5'd4);
        issue(5'd5);
        core_we_i    = 1'b1;
        core_waddr_i = 5'd1;
        set_result(1'b1, 5'd4, 32'h44);
        tick();
        do_reset();

        // Random legal traffic, with a reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            rand_cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
